// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : CPU, camera and RAM command signals shared with dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              cam_req;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_wdata;
    logic              cam_gnt;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cam_req, cam_addr, cam_wdata,
        input  ram_rdata,
        output cpu_rdata, cpu_stall, cam_gnt,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cam_req, cam_addr, cam_wdata,
        output ram_rdata,
        input  cpu_rdata, cpu_stall, cam_gnt,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Single-port data RAM arbiter, camera-priority with CPU
//               starvation guard after CAM_BURST consecutive camera grants.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int CAM_BURST = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dmem_arbiter_if.slave bus
);
    localparam int                RUN_W       = (CAM_BURST > 0) ? $clog2(CAM_BURST + 1) : 1;
    localparam logic [ADDR_W-1:0] C_ADDR_ZERO = '0;
    localparam logic [DATA_W-1:0] C_DATA_ZERO = '0;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_DATA = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [RUN_W-1:0]  r_cam_run;
    logic [RUN_W-1:0]  w_cam_run_nxt;
    logic [DATA_W-1:0] r_rdata_hold;
    logic              w_burst_done;
    logic              w_in_rd;
    logic              w_cpu_win;
    logic              w_cam_win;

    // With CAM_BURST=0 the CPU is never held off by the camera.
    generate
        if (CAM_BURST == 0) begin : g_strict
            assign w_burst_done = 1'b1;
        end else begin : g_burst
            localparam logic [RUN_W-1:0] C_BURST = RUN_W'(CAM_BURST);
            assign w_burst_done = (r_cam_run == C_BURST);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cam_run    <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cam_run <= w_cam_run_nxt;
            if (w_in_rd) begin
                r_rdata_hold <= bus.ram_rdata;
            end
        end
    end

    always_comb begin
        w_in_rd       = (r_state == ST_RD_DATA);
        w_cpu_win     = bus.cpu_req && !w_in_rd && (!bus.cam_req || w_burst_done);
        w_cam_win     = !w_cpu_win && bus.cam_req;
        w_state_nxt   = ST_IDLE;
        w_cam_run_nxt = r_cam_run;
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = C_ADDR_ZERO;
        bus.ram_wdata = C_DATA_ZERO;
        bus.cam_gnt   = 1'b0;
        bus.cpu_stall = 1'b0;
        bus.cpu_rdata = C_DATA_ZERO;

        if (w_cpu_win && !bus.cpu_we) begin
            w_state_nxt = ST_RD_DATA;
        end

        if (w_cpu_win || !bus.cpu_req) begin
            w_cam_run_nxt = '0;
        end else if (w_cam_win && !w_burst_done) begin
            w_cam_run_nxt = r_cam_run + RUN_W'(1);
        end

        // Every output is forced low while reset is held, not just the state.
        if (reset) begin
            if (w_cpu_win) begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = bus.cpu_we;
                bus.ram_addr  = bus.cpu_addr;
                bus.ram_wdata = bus.cpu_wdata;
            end else if (w_cam_win) begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = bus.cam_addr;
                bus.ram_wdata = bus.cam_wdata;
            end
            bus.cam_gnt   = w_cam_win;
            bus.cpu_stall = bus.cpu_req && !(w_cpu_win && bus.cpu_we) && !w_in_rd;
            bus.cpu_rdata = w_in_rd ? bus.ram_rdata : r_rdata_hold;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Bench for dmem_arbiter (CAM_BURST=4 and CAM_BURST=0 instances)
//               with directed cases and a randomized run against a reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic        cam_req   [2];
    logic [31:0] cam_addr  [2];
    logic [31:0] cam_wdata [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL dut%0d %s: got %h expected %h at %0t", k, nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int BURST = (g == 0) ? 4 : 0;

        dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

        logic [31:0] mem     [64];
        logic [31:0] ref_mem [64];
        logic [31:0] rd_q = '0;
        bit          m_rd;
        int          m_run;
        logic [31:0] m_load, m_hold;
        bit          cw, mw, e_en, e_we, e_stall;
        logic [31:0] e_addr, e_wd, e_rd;

        assign bus.cpu_req   = cpu_req[g];
        assign bus.cpu_we    = cpu_we[g];
        assign bus.cpu_addr  = cpu_addr[g];
        assign bus.cpu_wdata = cpu_wdata[g];
        assign bus.cam_req   = cam_req[g];
        assign bus.cam_addr  = cam_addr[g];
        assign bus.cam_wdata = cam_wdata[g];
        assign bus.ram_rdata = rd_q;

        dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .CAM_BURST(BURST)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );

        initial begin
            for (int i = 0; i < 64; i++) begin
                mem[i]     = (i == 17) ? 32'h1234_5678 : 32'hA500_0000 + i;
                ref_mem[i] = (i == 17) ? 32'h1234_5678 : 32'hA500_0000 + i;
            end
        end

        // Behavioural synchronous RAM, one-cycle read latency.
        always @(posedge clk) begin
            if (bus.ram_en && bus.ram_we) mem[bus.ram_addr[7:2]] <= bus.ram_wdata;
            if (bus.ram_en && !bus.ram_we) rd_q <= mem[bus.ram_addr[7:2]];
        end

        // Reference: who owns the RAM this cycle, and what a load must return.
        always @(negedge clk) begin
            if (!reset) begin
                m_rd = 0; m_run = 0; m_hold = '0;
                chk("rst_ram_en",    g, bus.ram_en,    0);
                chk("rst_ram_we",    g, bus.ram_we,    0);
                chk("rst_ram_addr",  g, bus.ram_addr,  0);
                chk("rst_ram_wdata", g, bus.ram_wdata, 0);
                chk("rst_cam_gnt",   g, bus.cam_gnt,   0);
                chk("rst_cpu_stall", g, bus.cpu_stall, 0);
                chk("rst_cpu_rdata", g, bus.cpu_rdata, 0);
            end else begin
                cw      = cpu_req[g] && !m_rd && (!cam_req[g] || m_run >= BURST);
                mw      = !cw && cam_req[g];
                e_en    = cw || mw;
                e_we    = mw || (cw && cpu_we[g]);
                e_addr  = cw ? cpu_addr[g] : (mw ? cam_addr[g] : 32'h0);
                e_wd    = cw ? cpu_wdata[g] : (mw ? cam_wdata[g] : 32'h0);
                e_stall = cpu_req[g] && !(cw && cpu_we[g]) && !m_rd;
                e_rd    = m_rd ? m_load : m_hold;
                chk("ram_en",    g, bus.ram_en,    e_en);
                chk("ram_we",    g, bus.ram_we,    e_we);
                chk("ram_addr",  g, bus.ram_addr,  e_addr);
                if (!e_en || e_we) chk("ram_wdata", g, bus.ram_wdata, e_wd);
                chk("cam_gnt",   g, bus.cam_gnt,   mw);
                chk("cpu_stall", g, bus.cpu_stall, e_stall);
                chk("cpu_rdata", g, bus.cpu_rdata, e_rd);
                if (m_rd) m_hold = m_load;
                m_rd = cw && !cpu_we[g];
                if (m_rd) m_load = ref_mem[cpu_addr[g][7:2]];
                if (cw && cpu_we[g]) ref_mem[cpu_addr[g][7:2]] = cpu_wdata[g];
                if (mw) ref_mem[cam_addr[g][7:2]] = cam_wdata[g];
                if (cw || !cpu_req[g]) m_run = 0;
                else if (mw && m_run < BURST) m_run++;
            end
        end
    end

    task automatic drv(input int k, input bit cr, input bit we, input logic [31:0] ca, input logic [31:0] cd,
                       input bit mr, input logic [31:0] ma, input logic [31:0] md);
        cpu_req[k] = cr; cpu_we[k] = we; cpu_addr[k] = ca; cpu_wdata[k] = cd;
        cam_req[k] = mr; cam_addr[k] = ma; cam_wdata[k] = md;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    bit cpu_ok [2];
    bit cam_ok [2];

    initial begin
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drv(k, 0, 0, 0, 0, 0, 0, 0);
            cpu_ok[k] = 0;
            cam_ok[k] = 0;
        end
        repeat (3) next_cycle();
        reset = 1'b1;

        // Store with camera idle: zero-latency grant.
        next_cycle();
        drv(0, 1, 1, 32'h40, 32'hDEAD_BEEF, 0, 0, 0);
        @(negedge clk);
        chk("t1_ram_en", 0, g_dut[0].bus.ram_en, 1);
        chk("t1_ram_we", 0, g_dut[0].bus.ram_we, 1);
        chk("t1_ram_addr", 0, g_dut[0].bus.ram_addr, 32'h40);
        chk("t1_ram_wdata", 0, g_dut[0].bus.ram_wdata, 32'hDEAD_BEEF);
        chk("t1_stall", 0, g_dut[0].bus.cpu_stall, 0);

        // Load: one stall cycle then data, held afterwards.
        next_cycle();
        drv(0, 1, 0, 32'h44, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_c0_stall", 0, g_dut[0].bus.cpu_stall, 1);
        chk("t2_c0_ram_en", 0, g_dut[0].bus.ram_en, 1);
        chk("t2_c0_ram_we", 0, g_dut[0].bus.ram_we, 0);
        next_cycle();
        @(negedge clk);
        chk("t2_c1_stall", 0, g_dut[0].bus.cpu_stall, 0);
        chk("t2_c1_rdata", 0, g_dut[0].bus.cpu_rdata, 32'h1234_5678);
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_c2_rdata", 0, g_dut[0].bus.cpu_rdata, 32'h1234_5678);

        // Camera burst of 4 then the waiting CPU store gets its slot.
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            drv(0, (c < 5), 1, 32'h80, 32'h1111_1111, 1, 32'h100 + 32'(c) * 4, 32'hCAFE_0000 + 32'(c));
            @(negedge clk);
            chk("t3_cam_gnt", 0, g_dut[0].bus.cam_gnt, (c == 4) ? 0 : 1);
            if (c == 4) begin
                chk("t3_c4_stall", 0, g_dut[0].bus.cpu_stall, 0);
                chk("t3_c4_addr", 0, g_dut[0].bus.ram_addr, 32'h80);
            end
        end

        // Camera write overlaps the load data cycle without a bubble.
        next_cycle();
        drv(0, 1, 0, 32'h44, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4_c0_stall", 0, g_dut[0].bus.cpu_stall, 1);
        next_cycle();
        drv(0, 1, 0, 32'h44, 0, 1, 32'h200, 32'h5555_AAAA);
        @(negedge clk);
        chk("t4_c1_cam_gnt", 0, g_dut[0].bus.cam_gnt, 1);
        chk("t4_c1_ram_we", 0, g_dut[0].bus.ram_we, 1);
        chk("t4_c1_rdata", 0, g_dut[0].bus.cpu_rdata, 32'h1234_5678);
        chk("t4_c1_stall", 0, g_dut[0].bus.cpu_stall, 0);

        // Reset asserted during the load data cycle.
        next_cycle();
        drv(0, 1, 0, 32'h40, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_c0_stall", 0, g_dut[0].bus.cpu_stall, 1);
        next_cycle();
        drv(0, 1, 0, 32'h40, 0, 1, 32'h204, 32'h7777_0000);
        chk("t5_pre_rdata", 0, g_dut[0].bus.cpu_rdata, 32'hDEAD_BEEF);
        reset = 1'b0;
        #1;
        chk("t5_rst_rdata", 0, g_dut[0].bus.cpu_rdata, 0);
        chk("t5_rst_gnt", 0, g_dut[0].bus.cam_gnt, 0);
        chk("t5_rst_en", 0, g_dut[0].bus.ram_en, 0);
        next_cycle();
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_post_rdata", 0, g_dut[0].bus.cpu_rdata, 0);
        chk("t5_post_stall", 0, g_dut[0].bus.cpu_stall, 0);
        chk("t5_post_en", 0, g_dut[0].bus.ram_en, 0);

        // CAM_BURST=0: CPU stores win every cycle.
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            drv(1, 1, 1, 32'h10 + 32'(c) * 4, 32'hB000_0000 + 32'(c), 1, 32'h300, 32'hC0C0_C0C0);
            @(negedge clk);
            chk("t6_cam_gnt", 1, g_dut[1].bus.cam_gnt, 0);
            chk("t6_stall", 1, g_dut[1].bus.cpu_stall, 0);
            chk("t6_addr", 1, g_dut[1].bus.ram_addr, 32'h10 + 32'(c) * 4);
        end
        next_cycle();
        drv(1, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic; requesters hold each request until served.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if (c == 1700) reset = 1'b0;
            if (c == 1702) reset = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (!cpu_req[k] || cpu_ok[k]) begin
                    cpu_req[k]   = ($urandom_range(0, 99) < 60);
                    cpu_we[k]    = 1'($urandom_range(0, 1));
                    cpu_addr[k]  = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2);
                    cpu_wdata[k] = $urandom;
                end
                if (!cam_req[k] || cam_ok[k]) begin
                    cam_req[k]   = ($urandom_range(0, 99) < 55);
                    cam_addr[k]  = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2);
                    cam_wdata[k] = $urandom;
                end
            end
            @(negedge clk);
            cpu_ok[0] = cpu_req[0] && !g_dut[0].bus.cpu_stall && reset;
            cpu_ok[1] = cpu_req[1] && !g_dut[1].bus.cpu_stall && reset;
            cam_ok[0] = cam_req[0] && g_dut[0].bus.cam_gnt;
            cam_ok[1] = cam_req[1] && g_dut[1].bus.cam_gnt;
        end

        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
